// File: rtl/fb_pkg.sv
// Shared constants and state encoding for the frame-buffer write-port controller.
package fb_pkg;
  localparam int unsigned H_RES = 160;
  localparam int unsigned V_RES = 120;
  localparam int unsigned NPIX  = H_RES * V_RES;
  localparam int unsigned AW    = 15;
  localparam int unsigned DW    = 12;
  localparam int unsigned CW    = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    FINISH = 2'd2
  } state_e;
endpackage

// File: rtl/fb_addr_calc.sv
// Maps (x, y) to a linear frame-buffer address, y*160 + x, and flags in-frame coordinates.
module fb_addr_calc
  import fb_pkg::*;
(
  input  logic [CW-1:0] x_i,
  input  logic [CW-1:0] y_i,
  output logic [AW-1:0] addr_o,
  output logic          in_range_o
);

  // The multiply by 160 is written as two shifts.
  assign addr_o     = (AW'(y_i) << 7) + (AW'(y_i) << 5) + AW'(x_i);
  assign in_range_o = (32'(x_i) < H_RES) && (32'(y_i) < V_RES);

endmodule

// File: rtl/fb_write_ctrl.sv
// Shares the frame-buffer write port between a pixel requester and a full-frame fill engine.
module fb_write_ctrl
  import fb_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          px_valid,
  output logic          px_ready,
  input  logic [CW-1:0] px_x,
  input  logic [CW-1:0] px_y,
  input  logic [DW-1:0] px_color,
  input  logic          clr_start,
  input  logic [DW-1:0] clr_color,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] drop_cnt,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          wr_en
);

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] color_q, color_d;
  logic [CW-1:0] drop_q, drop_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0] wr_data_q, wr_data_d;

  logic [AW-1:0] px_addr;
  logic          px_in_range;
  logic          px_accept;

  fb_addr_calc u_addr_calc (
    .x_i        (px_x),
    .y_i        (px_y),
    .addr_o     (px_addr),
    .in_range_o (px_in_range)
  );

  // A fill request takes priority over a pixel offered in the same cycle.
  assign px_ready  = (state_q == IDLE) && !clr_start;
  assign px_accept = px_valid && px_ready;

  assign busy     = (state_q == FILL) || (state_q == FINISH);
  assign done     = (state_q == FINISH);
  assign drop_cnt = drop_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;

  // Next-state and write-side register inputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    color_d   = color_q;
    drop_d    = drop_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    case (state_q)
      IDLE: begin
        if (clr_start) begin
          state_d = FILL;
          cnt_d   = '0;
          color_d = clr_color;
        end else if (px_accept) begin
          if (px_in_range) begin
            wr_en_d   = 1'b1;
            wr_addr_d = px_addr;
            wr_data_d = px_color;
          end else if (drop_q != '1) begin
            drop_d = drop_q + CW'(1);
          end
        end
      end
      FILL: begin
        // The counter runs one past the last address so FINISH follows the final write's cycle.
        if (cnt_q == AW'(NPIX)) begin
          state_d = FINISH;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = cnt_q;
          wr_data_d = color_q;
          cnt_d     = cnt_q + AW'(1);
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      color_q   <= '0;
      drop_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      color_q   <= color_d;
      drop_q    <= drop_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

endmodule

// File: tb/tb_fb_write_ctrl.sv
// Directed self-checking bench for fb_write_ctrl with a behavioural frame-buffer model.
module tb_fb_write_ctrl;

  logic        clk;
  logic        reset;
  logic        px_valid;
  logic        px_ready;
  logic [7:0]  px_x;
  logic [7:0]  px_y;
  logic [11:0] px_color;
  logic        clr_start;
  logic [11:0] clr_color;
  logic        busy;
  logic        done;
  logic [7:0]  drop_cnt;
  logic [14:0] wr_addr;
  logic [11:0] wr_data;
  logic        wr_en;

  int n_cmp = 0;
  int n_err = 0;

  logic [11:0] ram     [0:19199];
  logic [11:0] ref_img [0:19199];

  int fill_wr  = 0;
  int seq_bad  = 0;
  int data_bad = 0;
  int done_cnt = 0;

  fb_write_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .px_valid  (px_valid),
    .px_ready  (px_ready),
    .px_x      (px_x),
    .px_y      (px_y),
    .px_color  (px_color),
    .clr_start (clr_start),
    .clr_color (clr_color),
    .busy      (busy),
    .done      (done),
    .drop_cnt  (drop_cnt),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_en     (wr_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Buffer write port model plus fill-sequence observer.
  always @(posedge clk) begin
    if (wr_en && (wr_addr < 15'd19200)) ram[wr_addr] <= wr_data;
    if (wr_en && busy) begin
      if (wr_addr != 15'(fill_wr)) seq_bad <= seq_bad + 1;
      if (wr_data != 12'h0F0) data_bad <= data_bad + 1;
      fill_wr <= fill_wr + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  int          gap;
  int          rx;
  int          ry;
  int          rc;
  int          mism;
  logic [14:0] idx;

  initial begin
    reset     = 1'b1;
    px_valid  = 1'b0;
    px_x      = 8'd0;
    px_y      = 8'd0;
    px_color  = 12'h000;
    clr_start = 1'b0;
    clr_color = 12'h000;
    for (int a = 0; a < 19200; a++) ref_img[15'(a)] = 12'h0F0;
    ref_img[15'd167] = 12'h123;

    step();
    step();
    chk("rst_wr_en",   32'(wr_en),    32'd0);
    chk("rst_wr_addr", 32'(wr_addr),  32'd0);
    chk("rst_wr_data", 32'(wr_data),  32'd0);
    chk("rst_done",    32'(done),     32'd0);
    chk("rst_busy",    32'(busy),     32'd0);
    chk("rst_drop",    32'(drop_cnt), 32'd0);

    reset = 1'b0;
    step();
    chk("rel_px_ready", 32'(px_ready), 32'd1);

    // Corner pixel at the last address.
    px_valid = 1'b1; px_x = 8'd159; px_y = 8'd119; px_color = 12'hF00;
    step();
    px_valid = 1'b0;
    chk("corner_wr_en",   32'(wr_en),   32'd1);
    chk("corner_wr_addr", 32'(wr_addr), 32'd19199);
    chk("corner_wr_data", 32'(wr_data), 32'hF00);
    step();
    chk("corner_wr_en_off", 32'(wr_en), 32'd0);

    px_valid = 1'b1; px_x = 8'd0; px_y = 8'd0; px_color = 12'hABC;
    step();
    chk("origin_wr_addr", 32'(wr_addr), 32'd0);
    chk("origin_wr_data", 32'(wr_data), 32'hABC);

    // Back-to-back pixels.
    px_x = 8'd5; px_y = 8'd2; px_color = 12'h111;
    step();
    chk("b2b0_wr_addr", 32'(wr_addr), 32'd325);
    px_x = 8'd10; px_y = 8'd3; px_color = 12'h222;
    step();
    px_valid = 1'b0;
    chk("b2b1_wr_en",   32'(wr_en),   32'd1);
    chk("b2b1_wr_addr", 32'(wr_addr), 32'd490);
    chk("b2b1_wr_data", 32'(wr_data), 32'h222);

    // Out-of-range drops.
    px_valid = 1'b1; px_x = 8'd160; px_y = 8'd5;
    step();
    chk("oor_x_wr_en", 32'(wr_en),    32'd0);
    chk("oor_x_drop",  32'(drop_cnt), 32'd1);
    px_x = 8'd0; px_y = 8'd120;
    step();
    chk("oor_y_wr_en", 32'(wr_en),    32'd0);
    chk("oor_y_drop",  32'(drop_cnt), 32'd2);
    px_x = 8'd200; px_y = 8'd5;
    repeat (300) step();
    px_valid = 1'b0;
    chk("drop_sat",       32'(drop_cnt), 32'd255);
    chk("drop_sat_wr_en", 32'(wr_en),    32'd0);

    // Fill colliding with a pixel request.
    px_valid = 1'b1; px_x = 8'd7; px_y = 8'd1; px_color = 12'h123;
    clr_start = 1'b1; clr_color = 12'h0F0;
    #1;
    chk("collide_px_ready", 32'(px_ready), 32'd0);
    step();
    clr_start = 1'b0;
    chk("fill_e0_busy",     32'(busy),     32'd1);
    chk("fill_e0_wr_en",    32'(wr_en),    32'd0);
    chk("fill_e0_px_ready", 32'(px_ready), 32'd0);
    step();
    chk("fill_e1_wr_en",   32'(wr_en),   32'd1);
    chk("fill_e1_wr_addr", 32'(wr_addr), 32'd0);
    chk("fill_e1_wr_data", 32'(wr_data), 32'h0F0);
    repeat (19198) step();
    step();
    chk("fill_e19200_wr_en",   32'(wr_en),   32'd1);
    chk("fill_e19200_wr_addr", 32'(wr_addr), 32'd19199);
    chk("fill_e19200_done",    32'(done),    32'd0);
    chk("fill_e19200_busy",    32'(busy),    32'd1);
    step();
    chk("fill_e19201_done",  32'(done),  32'd1);
    chk("fill_e19201_wr_en", 32'(wr_en), 32'd0);
    chk("fill_e19201_busy",  32'(busy),  32'd1);
    step();
    chk("fill_e19202_done",     32'(done),     32'd0);
    chk("fill_e19202_busy",     32'(busy),     32'd0);
    chk("fill_e19202_px_ready", 32'(px_ready), 32'd1);
    step();
    px_valid = 1'b0;
    chk("held_wr_en",   32'(wr_en),   32'd1);
    chk("held_wr_addr", 32'(wr_addr), 32'd167);
    chk("held_wr_data", 32'(wr_data), 32'h123);
    step();
    chk("held_once",      32'(wr_en),    32'd0);
    chk("fill_count",     32'(fill_wr),  32'd19200);
    chk("fill_seq",       32'(seq_bad),  32'd0);
    chk("fill_data",      32'(data_bad), 32'd0);
    chk("done_pulse",     32'(done_cnt), 32'd1);
    chk("ram_last_fill",  32'(ram[15'd19199]), 32'h0F0);
    chk("ram_held_pixel", 32'(ram[15'd167]),   32'h123);

    // Random in-range stream with idle gaps.
    for (int i = 0; i < 1000; i++) begin
      px_valid = 1'b0;
      gap = $urandom_range(0, 2);
      repeat (gap) step();
      rx = $urandom_range(0, 159);
      ry = $urandom_range(0, 119);
      rc = $urandom_range(0, 4095);
      px_x = 8'(rx); px_y = 8'(ry); px_color = 12'(rc);
      px_valid = 1'b1;
      idx = 15'(ry * 160 + rx);
      ref_img[idx] = 12'(rc);
      step();
    end
    px_valid = 1'b0;
    step();
    step();
    mism = 0;
    for (int a = 0; a < 19200; a++) if (ram[15'(a)] !== ref_img[15'(a)]) mism++;
    chk("stream_image", 32'(mism), 32'd0);

    // Pixel registered in the clr_start cycle, then reset partway through the fill.
    px_valid = 1'b1; px_x = 8'd1; px_y = 8'd0; px_color = 12'h555;
    step();
    px_valid = 1'b0;
    clr_start = 1'b1; clr_color = 12'h00F;
    chk("pre_fill_wr_en",   32'(wr_en),   32'd1);
    chk("pre_fill_wr_addr", 32'(wr_addr), 32'd1);
    step();
    clr_start = 1'b0;
    repeat (500) step();
    chk("midfill_wr_addr", 32'(wr_addr), 32'd499);
    reset = 1'b1;
    #1;
    chk("midrst_wr_en", 32'(wr_en), 32'd0);
    chk("midrst_busy",  32'(busy),  32'd0);
    chk("midrst_done",  32'(done),  32'd0);
    step();
    step();
    reset = 1'b0;
    step();
    chk("midrst_px_ready", 32'(px_ready), 32'd1);
    chk("midrst_drop",     32'(drop_cnt), 32'd0);
    chk("midrst_no_done",  32'(done_cnt), 32'd1);
    chk("partial_written", 32'(ram[15'd498]), 32'h00F);
    chk("partial_kept",    32'(ram[15'd499]), 32'(ref_img[15'd499]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
